// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame length and the transmitter FSM encoding.
// Also imported by the SPI receiver.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage : spi_pkg

// File: rtl/module_tx_hold_reg_spi.sv
// One-entry valid/data hold register that queues the next transmit word
// while the current frame is still shifting.
module module_tx_hold_reg_spi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  take_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
    end else if (take_i) begin
      valid_o <= 1'b0;
    end
  end

  // NOTE: the data word is qualified by valid_o, so it needs no reset;
  // keeping it out of the reset block lets it map to plain enable flops.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_o <= data_i;
    end
  end

endmodule : module_tx_hold_reg_spi

// File: rtl/module_tx_shift_reg_spi.sv
// SPI transmit shift register (mode 0 pre-load) with load handshake and abort.
// Define SPI_TX_HOLD_BUF_EN to add a one-word hold buffer for back-to-back frames.
module module_tx_shift_reg_spi
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic                  shift_en_i,
  input  logic                  abort_i,
  output logic                  data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  tx_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;
  logic                  done_q;

  logic                  load_fire;
  logic                  shift_fire;
  logic                  last_shift;
  logic                  start_new;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] next_word;

  assign load_fire  = load_valid_i & load_ready_o;
  assign shift_fire = (state == SHIFT) & shift_en_i & ~abort_i;
  assign last_shift = shift_fire & (cnt == CNT_W'(1));

  // A fresh word enters the shift register either from IDLE or seamlessly on
  // the final strobe of the current frame (hold word first, else a same-cycle load).
  assign start_new  = ~abort_i & (((state == IDLE) & load_fire) |
                                  (last_shift & (hold_valid | load_fire)));
  assign next_word  = hold_valid ? hold_data : data_i;

`ifdef SPI_TX_HOLD_BUF_EN
  logic hold_load;
  logic hold_take;

  assign hold_load    = load_fire & (state == SHIFT) & ~last_shift & ~abort_i;
  assign hold_take    = last_shift & hold_valid;
  assign load_ready_o = ~hold_valid;

  module_tx_hold_reg_spi #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (abort_i),
    .load_i  (hold_load),
    .data_i  (data_i),
    .take_i  (hold_take),
    .valid_o (hold_valid),
    .data_o  (hold_data)
  );
`else
  assign hold_valid   = 1'b0;
  assign hold_data    = '0;
  assign load_ready_o = (state == IDLE);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_fire) state_nxt = SHIFT;
      SHIFT:   if (last_shift && !start_new) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_comb begin
    busy_o = (state == SHIFT);
    done_o = done_q;
    data_o = 1'b0;
    if (state == SHIFT) begin
      data_o = MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0];
    end
  end

  // Counter only decrements in SHIFT, where it is always >= 1, so it never wraps.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sreg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_shift;
      if (abort_i) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (start_new) begin
        sreg <= next_word;
        cnt  <= CNT_W'(DATA_WIDTH);
      end else if (shift_fire) begin
        sreg <= MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, sreg[DATA_WIDTH-1:1]};
        cnt  <= cnt - CNT_W'(1);
      end
    end
  end

endmodule : module_tx_shift_reg_spi

// File: tb/tb_module_tx_shift_reg_spi.sv
// Scoreboard bench for module_tx_shift_reg_spi (8-bit, MSB first) with a
// behavioural loopback receiver; hold-buffer scenario runs when SPI_TX_HOLD_BUF_EN is defined.
module tb_module_tx_shift_reg_spi;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       load_valid_i;
  logic       load_ready_o;
  logic       shift_en_i;
  logic       abort_i;
  logic       data_o;
  logic       busy_o;
  logic       done_o;

  int tests = 0;
  int fails = 0;

  logic       exp_bits[$];
  logic [7:0] exp_words[$];
  logic [7:0] rx_model = 8'h00;
  logic       done_prev = 1'b0;

  module_tx_shift_reg_spi #(
    .DATA_WIDTH (8),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .shift_en_i   (shift_en_i),
    .abort_i      (abort_i),
    .data_o       (data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the receiver model samples data_o on every strobe it sees while a
  // frame is in progress; each done_o pulse retires one expected word.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      done_prev = 1'b0;
    end else begin
      if (shift_en_i && busy_o && !abort_i) begin
        check("strobe_expected", (exp_bits.size() != 0), 1);
        if (exp_bits.size() != 0) check("serial_bit", data_o, exp_bits.pop_front());
        rx_model = {rx_model[6:0], data_o};
      end
      if (done_o) begin
        check("done_single_cycle", done_prev, 0);
        check("done_expected", (exp_words.size() != 0), 1);
        if (exp_words.size() != 0) check("loopback_word", rx_model, exp_words.pop_front());
      end
      done_prev = done_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [7:0] w);
    load_valid_i = 1'b1;
    data_i       = w;
    check("ready_before_load", load_ready_o, 1);
    step();
    load_valid_i = 1'b0;
    data_i       = 8'($urandom);
    check("busy_after_load", busy_o, 1);
    check("preload_first_bit", data_o, w[7]);
  endtask

  // Strobes bits first..last of word w, with gap-1 quiet cycles before each.
  task automatic do_strobes(input logic [7:0] w, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      repeat (gap - 1) step();
      exp_bits.push_back(w[7-i]);
      if (i == 7) exp_words.push_back(w);
      shift_en_i = 1'b1;
      step();
      shift_en_i = 1'b0;
    end
  endtask

  task automatic frame_end_checks();
    check("done_after_last", done_o, 1);
    check("idle_after_last", busy_o, 0);
    check("ready_after_last", load_ready_o, 1);
    check("data_zero_idle", data_o, 0);
    step();
    check("done_dropped", done_o, 0);
  endtask

  task automatic send_frame(input logic [7:0] w, input int gap);
    do_load(w);
    do_strobes(w, 0, 7, gap);
    frame_end_checks();
  endtask

  initial begin
    rst_i        = 1'b0;
    data_i       = 8'h00;
    load_valid_i = 1'b0;
    shift_en_i   = 1'b0;
    abort_i      = 1'b0;
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ready", load_ready_o, 1);
    step();
    rst_i = 1'b1;
    step();

    // 0xA5, strobes spaced 4 cycles
    send_frame(8'hA5, 4);

    // Loopback 0x3C with back-to-back strobes
    send_frame(8'h3C, 1);

    // Reset mid-frame
    do_load(8'hFF);
    do_strobes(8'hFF, 0, 2, 2);
    #3 rst_i = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_data", data_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_ready", load_ready_o, 1);
    step();
    rst_i = 1'b1;
    step();
    send_frame(8'h01, 2);

    // Abort together with a strobe
    do_load(8'h80);
    do_strobes(8'h80, 0, 1, 2);
    shift_en_i = 1'b1;
    abort_i    = 1'b1;
    step();
    shift_en_i = 1'b0;
    abort_i    = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_data", data_o, 0);
    check("abort_done", done_o, 0);
    check("abort_ready", load_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      shift_en_i = 1'b1;
      step();
      shift_en_i = 1'b0;
      check("idle_strobe_busy", busy_o, 0);
      check("idle_strobe_data", data_o, 0);
      check("idle_strobe_done", done_o, 0);
    end
    send_frame(8'h96, 1);

`ifdef SPI_TX_HOLD_BUF_EN
    // 0x81 then 0x7E queued in the hold register, 16 continuous strobes
    do_load(8'h81);
    load_valid_i = 1'b1;
    data_i       = 8'h7E;
    check("hold_ready_empty", load_ready_o, 1);
    do_strobes(8'h81, 0, 0, 1);
    load_valid_i = 1'b0;
    check("hold_ready_full", load_ready_o, 0);
    do_strobes(8'h81, 1, 7, 1);
    check("hold_done_first", done_o, 1);
    check("hold_still_busy", busy_o, 1);
    check("hold_next_first_bit", data_o, 0);
    check("hold_ready_drained", load_ready_o, 1);
    do_strobes(8'h7E, 0, 7, 1);
    frame_end_checks();
`else
    // A load raised in the last-shift cycle waits for IDLE
    do_load(8'h5A);
    do_strobes(8'h5A, 0, 6, 1);
    load_valid_i = 1'b1;
    data_i       = 8'hC3;
    check("ready_during_shift", load_ready_o, 0);
    do_strobes(8'h5A, 7, 7, 1);
    check("late_load_done", done_o, 1);
    check("late_load_not_taken", busy_o, 0);
    check("late_load_ready", load_ready_o, 1);
    step();
    load_valid_i = 1'b0;
    check("late_load_taken", busy_o, 1);
    check("late_load_first_bit", data_o, 1);
    do_strobes(8'hC3, 0, 7, 2);
    frame_end_checks();
`endif

    repeat (3) step();
    check("bits_drained", exp_bits.size(), 0);
    check("words_drained", exp_words.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_module_tx_shift_reg_spi

// File: doc/module_tx_shift_reg_spi.md
MODULE_TX_SHIFT_REG_SPI -- requirements
Module: module_tx_shift_reg_spi

Interface
REQ-001 Parameter DATA_WIDTH, default 8: frame length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB first.
REQ-003 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous reset, active-low.
REQ-005 data_i  input  DATA_WIDTH  parallel word to transmit.
REQ-006 load_valid_i  input  1  data_i valid, load request.
REQ-007 load_ready_o  output  1  block can accept a word this cycle.
REQ-008 shift_en_i  input  1  one-cycle strobe: advance serial output by one bit; shared with the SPI receiver's shift strobe.
REQ-009 abort_i  input  1  synchronous frame abort.
REQ-010 data_o  output  1  serial data line.
REQ-011 busy_o  output  1  frame in progress.
REQ-012 done_o  output  1  one-cycle pulse, frame fully shifted.

Function
REQ-013 FSM states IDLE and SHIFT only; reset state IDLE.
REQ-014 Load handshake SHALL complete on a rising edge with load_valid_i=1 and load_ready_o=1; the transfer is a single cycle, and data_i is ignored at all other times.
REQ-015 In IDLE, an accepted load SHALL write the shift register, set the bit counter to DATA_WIDTH, and enter SHIFT.
REQ-016 The first bit (per MSB_FIRST) SHALL appear on data_o in the cycle after load acceptance, before any shift_en_i strobe (SPI mode 0 pre-load).
REQ-017 In SHIFT, each cycle with shift_en_i=1 SHALL shift the register one position, refill with 0, and decrement the counter.
REQ-018 On the strobe that takes the counter from 1 to 0, done_o SHALL be 1 for the next cycle only, and the FSM SHALL leave SHIFT.
REQ-019 shift_en_i in IDLE SHALL be ignored (no state, counter or data_o change).
REQ-020 data_o SHALL be 0 in IDLE; busy_o SHALL equal (state==SHIFT).
REQ-021 Without hold buffer, load_ready_o SHALL equal (state==IDLE); a load requested in the last-shift cycle is accepted no earlier than the following cycle.
REQ-022 abort_i=1 SHALL force IDLE next cycle, clear the counter and the hold buffer, and drive data_o=0; no done_o is produced. abort_i has priority over load and shift in the same cycle.
REQ-023 Bit counter width SHALL be $clog2(DATA_WIDTH+1); it never wraps below 0.

Reset
REQ-024 Asserting rst_i low SHALL immediately force IDLE, counter=0, shift register=0, hold buffer empty, data_o=0, busy_o=0, done_o=0, and load_ready_o=1, including mid-frame.
REQ-025 The first load SHALL be accepted no earlier than the first rising edge after rst_i deasserts.

Configuration
REQ-026 Macro SPI_TX_HOLD_BUF_EN defined: one-entry hold register added; load_ready_o = !hold_valid in any state. In IDLE with the hold register empty, a load goes straight to the shift register. In SHIFT, a load fills the hold register.
REQ-027 With SPI_TX_HOLD_BUF_EN, on the last shift strobe with hold_valid=1 the hold word SHALL move to the shift register, the counter SHALL reload to DATA_WIDTH, the FSM SHALL stay in SHIFT, done_o SHALL pulse, and the new first bit SHALL appear on the next cycle (no idle gap).
REQ-028 Macro undefined: no hold register exists and REQ-021 applies.

Structure
REQ-029 Shared package spi_pkg SHALL hold the DATA_WIDTH default constant and typedef enum tx_state_e {IDLE, SHIFT}, and is shared with the receiver.
REQ-030 One sub-module, module_tx_hold_reg_spi (valid/data register with load/take), SHALL be instantiated only under SPI_TX_HOLD_BUF_EN.

Verification
REQ-031 Release reset, load 0xA5 (MSB_FIRST=1), then 8 strobes spaced 4 cycles -> data_o = 1,0,1,0,0,1,0,1; done_o one cycle after the 8th strobe; then IDLE with load_ready_o=1.
REQ-032 Loopback: data_o feeds the SPI receiver's data_i with a common shift_en_i; load 0x3C, 8 strobes -> receiver data_o = 0x3C.
REQ-033 Load 0xFF, 3 strobes, then pull rst_i low between edges -> outputs zero immediately, no done_o; the next load of 0x01 transmits correctly.
REQ-034 Load 0x80, 2 strobes, abort_i together with shift_en_i -> IDLE next cycle, data_o=0, no done_o; shift_en_i pulses while IDLE cause no change.
REQ-035 With SPI_TX_HOLD_BUF_EN: load 0x81, load 0x7E during the frame, 16 continuous strobes -> serial stream 10000001 01111110 with no gap; done_o pulses twice; load_ready_o=0 while the hold register is full.
